// File: rtl/v6502_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | v6502_pkg : shared addressing-mode bits, sequencer states, widths  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package v6502_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam int AM_X   = 6;
  localparam int AM_Y   = 5;
  localparam int AM_ACC = 4;
  localparam int AM_IMM = 3;
  localparam int AM_ZP  = 2;
  localparam int AM_ABS = 1;
  localparam int AM_IND = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OP_LO  = 3'd1,
    OP_HI  = 3'd2,
    PTR_LO = 3'd3,
    PTR_HI = 3'd4,
    INDEX  = 3'd5,
    FIXUP  = 3'd6,
    DONE   = 3'd7
  } addr_seq_state_t;

  // Exactly the ten encodings the core issues; everything else is rejected.
  function automatic logic am_legal(input logic [6:0] m);
    case (m)
      7'b0010000, 7'b0001000, 7'b0000100, 7'b1000100, 7'b0100100,
      7'b0000010, 7'b1000010, 7'b0100010, 7'b1000101, 7'b0100101: am_legal = 1'b1;
      default: am_legal = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_index_add.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addr_index_add : 6502 index adder, 8-bit zero-page or 16-bit wrap   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module addr_index_add
  import v6502_pkg::*;
(
  input  logic [ADDR_W-1:0] base,
  input  logic [DATA_W-1:0] index,
  input  logic              zp_wrap,
  output logic [ADDR_W-1:0] sum,
  output logic              page_cross
);

  logic [DATA_W:0]   lo_sum;
  logic [DATA_W-1:0] hi_sum;

  always_comb begin
    lo_sum = {1'b0, base[DATA_W-1:0]} + {1'b0, index};
    hi_sum = base[ADDR_W-1:DATA_W] + {{(DATA_W-1){1'b0}}, lo_sum[DATA_W]};
    if (zp_wrap) begin
      sum        = {{(ADDR_W-DATA_W){1'b0}}, lo_sum[DATA_W-1:0]};
      page_cross = 1'b0;
    end else begin
      sum        = {hi_sum, lo_sum[DATA_W-1:0]};
      page_cross = lo_sum[DATA_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/addr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addr_sequencer : multi-cycle effective-address sequencer for v6502  |
// | Option macro ADDR_SEQ_CYCLE_EXACT_EN adds INDEX/FIXUP cycles. Rev 1.0 |
// +--------------------------------------------------------------------+
module addr_sequencer
  import v6502_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        mode,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] reg_x,
  input  logic [DATA_W-1:0] reg_y,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ea,
  output logic [DATA_W-1:0] operand,
  output logic              ea_is_acc,
  output logic [1:0]        pc_inc,
  output logic              err
);

`ifdef ADDR_SEQ_CYCLE_EXACT_EN
  localparam bit CYCLE_EXACT = 1'b1;
`else
  localparam bit CYCLE_EXACT = 1'b0;
`endif

  addr_seq_state_t   state, state_d;
  logic [6:0]        mode_r, am;
  logic [DATA_W-1:0] x_r, y_r, lo_r, ptr_r, ptr_d, add_idx, res_operand;
  logic [ADDR_W-1:0] pc_r, addr_r, add_base, add_sum, res_ea;
  logic              legal, zp_index, add_zp, add_cross;

  // In IDLE the request is decoded straight from the inputs so ACC/illegal skip the bus.
  assign am       = (state == IDLE) ? mode : mode_r;
  assign legal    = am_legal(am);
  assign zp_index = am[AM_X] | (am[AM_Y] & ~am[AM_IND]);
  assign add_idx  = am[AM_X] ? x_r : (am[AM_Y] ? y_r : '0);
  assign add_zp   = (state == OP_LO) || (state == INDEX);

  always_comb begin
    case (state)
      OP_LO:   add_base = {8'h00, mem_rdata};
      INDEX:   add_base = {8'h00, lo_r};
      default: add_base = {mem_rdata, lo_r};
    endcase
  end

  addr_index_add u_index_add (
    .base       (add_base),
    .index      (add_idx),
    .zp_wrap    (add_zp),
    .sum        (add_sum),
    .page_cross (add_cross)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d     = state;
    res_ea      = '0;
    res_operand = '0;
    ptr_d       = ptr_r;
    case (state)
      IDLE: if (start) state_d = (!legal || am[AM_ACC]) ? DONE : OP_LO;
      OP_LO: if (mem_ack) begin
        ptr_d = mem_rdata;
        if (am[AM_IMM]) begin
          res_ea      = pc_r;
          res_operand = mem_rdata;
          state_d     = DONE;
        end else if (am[AM_ABS]) begin
          state_d = OP_HI;
        end else if (CYCLE_EXACT && zp_index) begin
          state_d = INDEX;
        end else if (am[AM_IND]) begin
          if (am[AM_X]) ptr_d = add_sum[DATA_W-1:0];
          state_d = PTR_LO;
        end else begin
          res_ea  = add_sum;
          state_d = DONE;
        end
      end
      INDEX: begin
        if (am[AM_IND]) begin
          ptr_d   = add_sum[DATA_W-1:0];
          state_d = PTR_LO;
        end else begin
          res_ea  = add_sum;
          state_d = DONE;
        end
      end
      OP_HI: if (mem_ack) begin
        res_ea  = add_sum;
        state_d = (CYCLE_EXACT && add_cross) ? FIXUP : DONE;
      end
      PTR_LO: if (mem_ack) state_d = PTR_HI;
      PTR_HI: if (mem_ack) begin
        res_ea  = am[AM_Y] ? add_sum : {mem_rdata, lo_r};
        state_d = (CYCLE_EXACT && am[AM_Y] && add_cross) ? FIXUP : DONE;
      end
      FIXUP: begin
        res_ea  = addr_r;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r    <= '0;
      x_r       <= '0;
      y_r       <= '0;
      pc_r      <= '0;
      lo_r      <= '0;
      ptr_r     <= '0;
      addr_r    <= '0;
      ea        <= '0;
      operand   <= '0;
      ea_is_acc <= 1'b0;
      pc_inc    <= 2'd0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_r <= mode;
        x_r    <= reg_x;
        y_r    <= reg_y;
        pc_r   <= pc;
      end
      if ((state == OP_LO || state == PTR_LO) && mem_ack) lo_r <= mem_rdata;
      if ((state == OP_HI || state == PTR_HI) && mem_ack) addr_r <= add_sum;
      ptr_r <= ptr_d;
      // Results change only when a sequence completes, so they hold between requests.
      if (state != DONE && state_d == DONE) begin
        ea        <= res_ea;
        operand   <= res_operand;
        ea_is_acc <= legal & am[AM_ACC];
        pc_inc    <= (!legal || am[AM_ACC]) ? 2'd0 : (am[AM_ABS] ? 2'd2 : 2'd1);
        err       <= ~legal;
      end
    end
  end

  always_comb begin
    case (state)
      OP_LO:   mem_addr = pc_r;
      OP_HI:   mem_addr = pc_r + 16'd1;
      PTR_LO:  mem_addr = {8'h00, ptr_r};
      PTR_HI:  mem_addr = {8'h00, ptr_r + 8'd1};
      default: mem_addr = '0;
    endcase
  end

  assign mem_req = (state == OP_LO) || (state == OP_HI) || (state == PTR_LO) || (state == PTR_HI);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_addr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_addr_sequencer : directed scoreboard bench for addr_sequencer    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_addr_sequencer;

`ifdef ADDR_SEQ_CYCLE_EXACT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  mode = '0;
  logic [15:0] pc = '0;
  logic [7:0]  reg_x = '0, reg_y = '0;
  logic        mem_req, mem_ack = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        busy, done, ea_is_acc, err;
  logic [15:0] ea;
  logic [7:0]  operand;
  logic [1:0]  pc_inc;

  addr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pc(pc),
    .reg_x(reg_x), .reg_y(reg_y), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .ea(ea), .operand(operand), .ea_is_acc(ea_is_acc), .pc_inc(pc_inc), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ea;
    logic [7:0]  operand;
    logic        acc;
    logic [1:0]  inc;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] reads[$];
  logic [7:0]  mem [0:65535];
  int checks = 0, failures = 0, cyc = 0, wait_n = 0, req_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: wait_n stall cycles then ack; logs each completed read.
  initial begin
    int cnt;
    logic [15:0] a0;
    cnt = 0;
    a0  = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        if (cnt == 0) a0 = mem_addr;
        else check("mem_addr_stable", mem_addr, a0);
        if (cnt >= wait_n) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          reads.push_back(mem_addr);
          cnt = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'h5A;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        cnt     = 0;
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ea", ea, e.ea);
          check("operand", operand, e.operand);
          check("ea_is_acc", ea_is_acc, e.acc);
          check("pc_inc", pc_inc, e.inc);
          check("err", err, e.err);
          check("latency", cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [6:0] m, input logic [15:0] p, input logic [7:0] x, y,
                       output int t0);
    @(negedge clk);
    mode = m; pc = p; reg_x = x; reg_y = y; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0; mode = 7'h7F; pc = 16'hDEAD; reg_x = 8'hEE; reg_y = 8'hEE;
  endtask

  task automatic wait_sb(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input string tag, input logic [6:0] m, input logic [15:0] p,
                        input logic [7:0] x, y, input int wn,
                        input logic [15:0] e_ea, input logic [7:0] e_op, input logic e_acc,
                        input logic [1:0] e_inc, input logic e_err, input int e_lat,
                        input int nr, input logic [15:0] r0, r1, r2);
    exp_t e;
    logic [15:0] rexp [3];
    int t0;
    rexp[0] = r0; rexp[1] = r1; rexp[2] = r2;
    wait_n = wn;
    reads.delete();
    @(negedge clk);
    e.ea = e_ea; e.operand = e_op; e.acc = e_acc; e.inc = e_inc; e.err = e_err;
    e.lat = e_lat; e.t0 = cyc + 1;
    sb.push_back(e);
    issue(m, p, x, y, t0);
    wait_sb(tag);
    check({tag, "_nreads"}, reads.size(), nr);
    for (int i = 0; i < nr && i < reads.size(); i++) check({tag, "_read"}, reads[i], rexp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc, t0;
    exp_t e;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0200] = 8'hF0;
    mem[16'h0300] = 8'h34; mem[16'h0301] = 8'h12;
    mem[16'h0400] = 8'hFF; mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h80;
    mem[16'h0500] = 8'hA9;
    mem[16'h0600] = 8'hFE; mem[16'h0001] = 8'hCD; mem[16'h0002] = 8'hAB;
    mem[16'hFFFF] = 8'hF0;
    mem[16'h0700] = 8'hF0; mem[16'h0701] = 8'hFF;
    mem[16'h0800] = 8'h44;
    mem[16'h0900] = 8'h10;
    mem[16'h0A00] = 8'h78; mem[16'h0A01] = 8'h56;
    mem[16'h0C00] = 8'h10; mem[16'h0010] = 8'hF0; mem[16'h0011] = 8'h12;

    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ea", ea, 16'h0000);
    check("rst_outs", {operand, ea_is_acc, pc_inc, err}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("zpx",  7'b1000100, 16'h0200, 8'h20, 8'h00, 0, 16'h0010, 8'h00, 1'b0, 2'd1, 1'b0,
           CE ? 3 : 2, 1, 16'h0200, 16'h0, 16'h0);
    run_op("absy", 7'b0100010, 16'h0300, 8'h00, 8'hFF, 0, 16'h1333, 8'h00, 1'b0, 2'd2, 1'b0,
           CE ? 4 : 3, 2, 16'h0300, 16'h0301, 16'h0);
    repeat (3) @(negedge clk);
    #1;
    check("ea_hold", ea, 16'h1333);
    check("pc_inc_hold", pc_inc, 2'd2);
    run_op("indy", 7'b0100101, 16'h0400, 8'h00, 8'h05, 0, 16'h8005, 8'h00, 1'b0, 2'd1, 1'b0,
           4, 3, 16'h0400, 16'h00FF, 16'h0000);
    run_op("imm_wait", 7'b0001000, 16'h0500, 8'h00, 8'h00, 3, 16'h0500, 8'hA9, 1'b0, 2'd1, 1'b0,
           5, 1, 16'h0500, 16'h0, 16'h0);
    rc = req_cycles;
    run_op("illegal_xy", 7'b1100000, 16'h0500, 8'h00, 8'h00, 0, 16'h0000, 8'h00, 1'b0, 2'd0, 1'b1,
           1, 0, 16'h0, 16'h0, 16'h0);
    check("illegal_no_req", req_cycles - rc, 0);
    run_op("acc", 7'b0010000, 16'h0500, 8'h00, 8'h00, 0, 16'h0000, 8'h00, 1'b1, 2'd0, 1'b0,
           1, 0, 16'h0, 16'h0, 16'h0);
    run_op("indx", 7'b1000101, 16'h0600, 8'h03, 8'h00, 0, 16'hABCD, 8'h00, 1'b0, 2'd1, 1'b0,
           CE ? 5 : 4, 3, 16'h0600, 16'h0001, 16'h0002);
    run_op("abs_pcwrap", 7'b0000010, 16'hFFFF, 8'h00, 8'h00, 0, 16'h80F0, 8'h00, 1'b0, 2'd2, 1'b0,
           3, 2, 16'hFFFF, 16'h0000, 16'h0);
    run_op("absx_eawrap", 7'b1000010, 16'h0700, 8'h20, 8'h00, 0, 16'h0010, 8'h00, 1'b0, 2'd2, 1'b0,
           CE ? 4 : 3, 2, 16'h0700, 16'h0701, 16'h0);
    run_op("zp", 7'b0000100, 16'h0800, 8'h11, 8'h22, 0, 16'h0044, 8'h00, 1'b0, 2'd1, 1'b0,
           2, 1, 16'h0800, 16'h0, 16'h0);
    run_op("zpy_wait", 7'b0100100, 16'h0900, 8'h00, 8'h05, 1, 16'h0015, 8'h00, 1'b0, 2'd1, 1'b0,
           CE ? 4 : 3, 1, 16'h0900, 16'h0, 16'h0);
    run_op("indy_cross", 7'b0100101, 16'h0C00, 8'h00, 8'h20, 0, 16'h1310, 8'h00, 1'b0, 2'd1, 1'b0,
           CE ? 5 : 4, 3, 16'h0C00, 16'h0010, 16'h0011);
    run_op("illegal_ind", 7'b0000001, 16'h0C00, 8'h00, 8'h00, 0, 16'h0000, 8'h00, 1'b0, 2'd0, 1'b1,
           1, 0, 16'h0, 16'h0, 16'h0);

    // A start pulse during an ABS run must be dropped.
    wait_n = 0;
    reads.delete();
    @(negedge clk);
    e.ea = 16'h5678; e.operand = 8'h00; e.acc = 1'b0; e.inc = 2'd2; e.err = 1'b0;
    e.lat = 3; e.t0 = cyc + 1;
    sb.push_back(e);
    issue(7'b0000010, 16'h0A00, 8'h00, 8'h00, t0);
    mode = 7'b0010000; start = 1'b1;
    #1;
    check("busy_mid_abs", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_sb("abs_ignored");
    repeat (5) @(negedge clk);
    check("abs_ignored_nreads", reads.size(), 2);

    // Reset while OP_HI is stalled on the bus.
    wait_n = 4;
    reads.delete();
    issue(7'b0000010, 16'h0B00, 8'h00, 8'h00, t0);
    repeat (6) @(negedge clk);
    #1;
    check("pre_rst_req", mem_req, 1'b1);
    check("pre_rst_addr", mem_addr, 16'h0B01);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_req", mem_req, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_op("zp_after_rst", 7'b0000100, 16'h0800, 8'h00, 8'h00, 0, 16'h0044, 8'h00, 1'b0, 2'd1, 1'b0,
           2, 1, 16'h0800, 16'h0, 16'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
